// File: rtl/tqvp_multiplexed_hex_display.sv
// Multi-digit hex display peripheral for the TinyQV bus: double-buffered digit file, scan engine, PWM.
// Build macro TQVP_MHD_DEADTIME_EN blanks digit select for the first two phases of each slot.
module tqvp_multiplexed_hex_display #(
    parameter int unsigned DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        address,
    input  logic              data_write,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [7:0]        uo_out,
    output logic [DIGITS-1:0] dig_out
);

    localparam int unsigned      IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIGITS-1:0][3:0] shadow_q;
    logic [DIGITS-1:0][3:0] disp_q;
    logic                   buf_mode_q;
    logic                   lzs_q;
    logic                   lt_q;
    logic                   bi_q;
    logic                   al_q;
    logic [7:0]             dp_q;
    logic [7:0]             bright_q;
    logic [7:0]             div_q;
    logic [7:0]             pre_q;
    logic [7:0]             phase_q;
    logic [7:0]             frame_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   pending_q;

    logic                   tick_c;
    logic                   frame_end_c;
    logic                   commit_c;
    logic                   wr_commit_c;
    logic [3:0]             cur_digit_c;
    logic                   cur_dp_c;
    logic                   blank_c;
    logic                   zero_run_c;
    logic                   active_c;
    logic [7:0]             seg_c;
    logic [DIGITS-1:0]      dig_c;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan timing strobes; the frame boundary is the wrap of the last digit's final phase
    always_comb begin
        tick_c      = (pre_q >= div_q);
        frame_end_c = tick_c && (phase_q == 8'hFF) && (idx_q == LAST_IDX);
        commit_c    = frame_end_c && pending_q;
        wr_commit_c = data_write && (address == 4'h8);
    end

    // Register file, scan counters and commit handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            disp_q     <= '0;
            buf_mode_q <= 1'b0;
            lzs_q      <= 1'b1;
            lt_q       <= 1'b1;
            bi_q       <= 1'b1;
            al_q       <= 1'b1;
            dp_q       <= 8'h00;
            bright_q   <= 8'hFF;
            div_q      <= 8'h00;
            pre_q      <= 8'h00;
            phase_q    <= 8'h00;
            frame_q    <= 8'h00;
            idx_q      <= '0;
            pending_q  <= 1'b0;
        end else begin
            pre_q <= tick_c ? 8'h00 : pre_q + 8'd1;
            if (tick_c) begin
                phase_q <= phase_q + 8'd1;
                if (phase_q == 8'hFF) begin
                    idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                end
            end
            if (frame_end_c) begin
                frame_q <= frame_q + 8'd1;
            end
            if (commit_c) begin
                disp_q <= shadow_q;
            end
            if (wr_commit_c) begin
                pending_q <= 1'b1;
            end else if (commit_c) begin
                pending_q <= 1'b0;
            end
            if (data_write) begin
                // A commit copy in the same cycle keeps the old shadow in the display buffer
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (address == 4'(i / 2)) begin
                        shadow_q[i] <= data_in[4*(i%2) +: 4];
                        if (!buf_mode_q && !commit_c) begin
                            disp_q[i] <= data_in[4*(i%2) +: 4];
                        end
                    end
                end
                case (address)
                    4'h4:    {buf_mode_q, lzs_q, lt_q, bi_q, al_q} <= data_in[7:3];
                    4'h5:    dp_q     <= data_in;
                    4'h6:    bright_q <= data_in;
                    4'h7:    div_q    <= data_in;
                    default: ;
                endcase
            end
        end
    end

    // Segment and digit-select values for the digit currently being scanned
    always_comb begin
        cur_digit_c = 4'h0;
        blank_c     = 1'b0;
        zero_run_c  = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run_c = zero_run_c && (disp_q[i] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                cur_digit_c = disp_q[i];
                blank_c     = lzs_q && (i != 0) && zero_run_c && !dp_q[i];
            end
        end
        cur_dp_c = dp_q[idx_q];

        if (!lt_q) begin
            seg_c = 8'hFF;
        end else if (blank_c) begin
            seg_c = 8'h00;
        end else begin
            seg_c = {cur_dp_c, hex_seg(cur_digit_c)};
        end

`ifdef TQVP_MHD_DEADTIME_EN
        active_c = bi_q && (phase_q < bright_q) && (phase_q >= 8'd2);
`else
        active_c = bi_q && (phase_q < bright_q);
`endif

        dig_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig_c[i] = active_c && (idx_q == IDX_W'(i));
        end
    end

    // Output registers with optional active-low polarity
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_out  <= 8'hFF;
            dig_out <= '1;
        end else begin
            uo_out  <= al_q ? ~seg_c : seg_c;
            dig_out <= al_q ? ~dig_c : dig_c;
        end
    end

    // Bus read mux
    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (address == 4'(i / 2)) begin
                        data_out[4*(i%2) +: 4] = shadow_q[i];
                    end
                end
            end
            4'h4:    data_out = {buf_mode_q, lzs_q, lt_q, bi_q, al_q, 3'b000};
            4'h5:    data_out = dp_q;
            4'h6:    data_out = bright_q;
            4'h7:    data_out = div_q;
            4'h8:    data_out = {pending_q, 4'b0000, idx_q};
            4'h9:    data_out = frame_q;
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_multiplexed_hex_display.sv
// Bench for tqvp_multiplexed_hex_display (DIGITS=4): register table, directed scan scenarios,
// and random bus traffic against a tick-count based reference model.
module tb_tqvp_multiplexed_hex_display;

    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   address;
    logic         data_write;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic [7:0]   uo_out;
    logic [D-1:0] dig_out;

    int n_cmp = 0;
    int n_bad = 0;

    tqvp_multiplexed_hex_display #(.DIGITS(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .uo_out     (uo_out),
        .dig_out    (dig_out)
    );

    always #5 clk = ~clk;

    // Reference model: scan position derived from the total number of prescaler ticks
    int         m_ticks;
    int         m_since;
    logic [3:0] m_sh   [8];
    logic [3:0] m_disp [8];
    logic       m_buf, m_lzs, m_lt, m_bi, m_al, m_pend;
    logic [7:0] m_dp, m_br, m_div;
    logic [6:0] hexseg [16];

    function automatic int m_phase();
        return m_ticks % 256;
    endfunction

    function automatic int m_idx();
        return (m_ticks / 256) % D;
    endfunction

    function automatic int m_frame();
        return (m_ticks / (256 * D)) % 256;
    endfunction

    function automatic logic next_is_boundary();
        return (m_since >= int'(m_div)) && (m_phase() == 255) && (m_idx() == D - 1);
    endfunction

    task automatic model_reset();
        m_ticks = 0;
        m_since = 0;
        for (int i = 0; i < 8; i++) begin
            m_sh[i]   = 4'h0;
            m_disp[i] = 4'h0;
        end
        m_buf = 1'b0; m_lzs = 1'b1; m_lt = 1'b1; m_bi = 1'b1; m_al = 1'b1;
        m_pend = 1'b0;
        m_dp = 8'h00; m_br = 8'hFF; m_div = 8'h00;
    endtask

    task automatic model_out(output logic [7:0] eu, output logic [D-1:0] ed);
        int ix;
        int ph;
        logic blank;
        logic act;
        logic [7:0] seg;
        ix = m_idx();
        ph = m_phase();
        blank = m_lzs && (ix != 0) && !m_dp[ix];
        for (int j = ix; j < D; j++) begin
            if (m_disp[j] != 4'h0) blank = 1'b0;
        end
        if (!m_lt)      seg = 8'hFF;
        else if (blank) seg = 8'h00;
        else            seg = {m_dp[ix], hexseg[m_disp[ix]]};
        act = m_bi && (ph < int'(m_br));
`ifdef TQVP_MHD_DEADTIME_EN
        act = act && (ph >= 2);
`endif
        ed = '0;
        if (act) ed[ix] = 1'b1;
        eu = m_al ? ~seg : seg;
        if (m_al) ed = ~ed;
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a);
        logic [7:0] r;
        int lo;
        r  = 8'h00;
        lo = 2 * int'(a);
        case (a)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                if (lo < D)     r[3:0] = m_sh[lo];
                if (lo + 1 < D) r[7:4] = m_sh[lo+1];
            end
            4'h4: r = {m_buf, m_lzs, m_lt, m_bi, m_al, 3'b000};
            4'h5: r = m_dp;
            4'h6: r = m_br;
            4'h7: r = m_div;
            4'h8: r = {m_pend, 4'b0000, 3'(m_idx())};
            4'h9: r = 8'(m_frame());
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic model_edge(input logic rst, input logic we, input logic [3:0] a, input logic [7:0] d);
        logic tick;
        logic commit;
        int   i;
        if (rst) begin
            model_reset();
            return;
        end
        tick   = (m_since >= int'(m_div));
        commit = next_is_boundary() && m_pend;
        if (commit) begin
            for (int k = 0; k < 8; k++) m_disp[k] = m_sh[k];
            m_pend = 1'b0;
        end
        if (we) begin
            if (a < 4'h4) begin
                for (int h = 0; h < 2; h++) begin
                    i = 2 * int'(a) + h;
                    if (i < D) begin
                        m_sh[i] = (h == 1) ? d[7:4] : d[3:0];
                        if (!m_buf && !commit) m_disp[i] = m_sh[i];
                    end
                end
            end
            case (a)
                4'h4: {m_buf, m_lzs, m_lt, m_bi, m_al} = d[7:3];
                4'h5: m_dp  = d;
                4'h6: m_br  = d;
                4'h7: m_div = d;
                4'h8: m_pend = 1'b1;
                default: ;
            endcase
        end
        if (tick) begin
            m_since = 0;
            m_ticks = m_ticks + 1;
        end else begin
            m_since = m_since + 1;
        end
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare the display buses
    task automatic step(input logic rst, input logic we, input logic [3:0] a, input logic [7:0] d);
        logic [7:0]   eu;
        logic [D-1:0] ed;
        rst_n      = !rst;
        data_write = we;
        address    = a;
        data_in    = d;
        if (rst) begin
            eu = 8'hFF;
            ed = '1;
        end else begin
            model_out(eu, ed);
        end
        model_edge(rst, we, a, d);
        @(posedge clk);
        #1;
        check("uo_out", uo_out, eu);
        check("dig_out", 8'(dig_out), 8'(ed));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'hF, 8'h00);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b0, a, 8'h00);
        check($sformatf("read[%0h]", a), data_out, model_read(a));
    endtask

    task automatic wait_dig(input logic [D-1:0] tgt, input int bound);
        int n;
        n = 0;
        while (dig_out !== tgt && n < bound) begin
            idle(1);
            n++;
        end
        if (dig_out !== tgt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_dig: dig_out stayed %b, wanted %b", dig_out, tgt);
        end
    endtask

    // Enter the slot of digit i freshly (active-low select)
    task automatic goto_digit(input int i);
        logic [D-1:0] t;
        t = '0;
        t[(i + D - 1) % D] = 1'b1;
        wait_dig(~t, 3000);
        t = '0;
        t[i] = 1'b1;
        wait_dig(~t, 3000);
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int cnt;
        logic [3:0] a;
        logic [7:0] d;

        hexseg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vt[0]  = '{1'b0, 4'h4, 8'h00, 8'h78};
        vt[1]  = '{1'b0, 4'h5, 8'h00, 8'h00};
        vt[2]  = '{1'b0, 4'h6, 8'h00, 8'hFF};
        vt[3]  = '{1'b0, 4'h7, 8'h00, 8'h00};
        vt[4]  = '{1'b0, 4'h8, 8'h00, 8'h00};
        vt[5]  = '{1'b0, 4'hA, 8'h00, 8'h00};
        vt[6]  = '{1'b1, 4'h0, 8'h21, 8'h21};
        vt[7]  = '{1'b1, 4'h1, 8'h43, 8'h43};
        vt[8]  = '{1'b1, 4'h2, 8'hAB, 8'h00};
        vt[9]  = '{1'b1, 4'h3, 8'hCD, 8'h00};
        vt[10] = '{1'b1, 4'h5, 8'hA5, 8'hA5};
        vt[11] = '{1'b1, 4'h4, 8'hFF, 8'hF8};
        vt[12] = '{1'b1, 4'h6, 8'h40, 8'h40};
        vt[13] = '{1'b1, 4'h7, 8'h03, 8'h03};
        vt[14] = '{1'b1, 4'hC, 8'h12, 8'h00};

        model_reset();

        // Reset state
        step(1'b1, 1'b0, 4'h9, 8'h00);
        check("reset_uo", uo_out, 8'hFF);
        check("reset_dig", 8'(dig_out), 8'h0F);
        check("reset_frame", data_out, 8'h00);

        // Register map table
        for (int k = 0; k < NV; k++) begin
            if (vt[k].wr) wr(vt[k].a, vt[k].d);
            rd(vt[k].a);
            check($sformatf("table[%0d]", k), data_out, vt[k].exp);
        end

        // Basic scan: digits 4321
        step(1'b1, 1'b0, 4'hF, 8'h00);
        wr(4'h0, 8'h21);
        wr(4'h1, 8'h43);
        idle(2);
        check("digit0_seg", uo_out, 8'hF9);
        check("digit0_sel", 8'(dig_out), 8'h0E);
        goto_digit(3);
        check("digit3_seg", uo_out, 8'h99);

        // Leading-zero suppression and decimal point
        wr(4'h0, 8'h07);
        wr(4'h1, 8'h00);
        goto_digit(3);
        check("lzs_digit3", uo_out, 8'hFF);
        goto_digit(1);
        check("lzs_digit1", uo_out, 8'hFF);
        goto_digit(0);
        check("lzs_digit0", uo_out, 8'hF8);
        wr(4'h5, 8'h04);
        goto_digit(2);
        check("dp_digit2", uo_out, 8'h40);
        goto_digit(3);
        check("dp_digit3_blank", uo_out, 8'hFF);

        // Buffered update with commit
        wr(4'h5, 8'h00);
        wr(4'h4, 8'hF8);
        wr(4'h0, 8'h99);
        goto_digit(0);
        check("buf_unchanged", uo_out, 8'hF8);
        wr(4'h8, 8'h00);
        rd(4'h8);
        check("pending_set", {7'b0, data_out[7]}, 8'h01);
        n = 0;
        while (data_out[7] && n < 1200) begin
            rd(4'h8);
            n++;
        end
        check("commit_status", data_out, 8'h00);
        idle(2);
        check("commit_digit0", uo_out, 8'h90);

        // Brightness PWM over one whole frame
        wr(4'h4, 8'h78);
        wr(4'h6, 8'h40);
        idle(2);
        cnt = 0;
        for (int k = 0; k < 256 * D; k++) begin
            idle(1);
            if (dig_out !== '1) cnt++;
        end
`ifdef TQVP_MHD_DEADTIME_EN
        check("pwm_active", 8'(cnt / D), 8'd62);
`else
        check("pwm_active", 8'(cnt / D), 8'd64);
`endif

        // Lamp test, blanking input, polarity
        wr(4'h4, 8'h58);
        idle(2);
        check("lamp_test", uo_out, 8'h00);
        wr(4'h4, 8'h68);
        idle(2);
        check("blank_input", 8'(dig_out), 8'h0F);
        wr(4'h4, 8'h70);
        wait_dig(4'b0001, 3000);
        check("active_high_seg", uo_out, 8'h6F);
        wr(4'h4, 8'h78);

        // Commit write coincident with a frame boundary
        step(1'b1, 1'b0, 4'hF, 8'h00);
        wr(4'h4, 8'hF8);
        wr(4'h0, 8'h05);
        n = 0;
        while (!next_is_boundary() && n < 1100) begin
            idle(1);
            n++;
        end
        check("found_boundary", {7'b0, next_is_boundary()}, 8'h01);
        wr(4'h8, 8'h00);
        rd(4'h8);
        check("pend_coinc", {7'b0, data_out[7]}, 8'h01);
        n = 0;
        while (data_out[7] && n < 1200) begin
            rd(4'h8);
            n++;
        end
        check("coinc_status", data_out, 8'h00);
        check("coinc_delay", {7'b0, n >= 1000}, 8'h01);
        idle(2);
        check("coinc_digit0", uo_out, 8'h92);

        // Reset in the middle of a slot
        idle(300);
        rd(4'h9);
        step(1'b1, 1'b0, 4'h9, 8'h00);
        check("midreset_uo", uo_out, 8'hFF);
        check("midreset_dig", 8'(dig_out), 8'h0F);
        check("midreset_frame", data_out, 8'h00);

        // Random bus traffic against the model
        step(1'b1, 1'b0, 4'hF, 8'h00);
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                a = 4'($urandom_range(0, 15));
                d = 8'($urandom);
                if (a == 4'h7) d = 8'($urandom_range(0, 3));
                wr(a, d);
            end else begin
                rd(4'($urandom_range(0, 15)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tqvp_multiplexed_hex_display.md
# tqvp_multiplexed_hex_display

Parametrised multi-digit successor to the single-digit TinyQV display decoder peripheral. Holds up to 8 hex digits in a double-buffered register file. Time-multiplexes them onto one shared 8-bit segment bus plus a one-hot digit-select bus, with leading-zero suppression across digits, per-digit decimal points and PWM brightness. Sits on the TinyQV peripheral bus (4-bit address, 8-bit data).

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits, legal 1..8; digit DIGITS-1 is most significant.

Ports:
- clk  in  1  clock (64 MHz nominal)
- rst_n  in  1  reset, synchronous, active-low
- address  in  4  register address
- data_write  in  1  write strobe, data_in valid this cycle
- data_in  in  8  write data
- data_out  out  8  read data, combinational from address
- uo_out  out  8  registered segments {dp,g,f,e,d,c,b,a}
- dig_out  out  DIGITS  registered one-hot digit select

## Operation
Register map (reads of unlisted addresses return 0):
- 0x0-0x3: shadow digits; addr k: [3:0]=digit 2k, [7:4]=digit 2k+1. Nibbles for digits >= DIGITS are not stored and read 0.
- 0x4: control {buf, lzs, lt, bi, al, 000}. Reset 0x78.
  - buf=1: shadow is copied to the display buffer only on commit.
  - buf=0: shadow writes also update the display buffer.
- 0x5: dp mask, bit i = decimal point of digit i. Reset 0x00.
- 0x6: brightness. Reset 0xFF.
- 0x7: prescale div. Reset 0x00.
- 0x8: any write sets commit pending. Read returns {pending, 0000, idx[2:0]}.
- 0x9: read returns frame counter (8-bit, wraps).

Scan engine:
- Prescaler pre (8-bit): when pre >= div, tick and pre<=0, else pre++.
- Phase (8-bit) increments on each tick. On tick with phase==255:
  - idx advances; it wraps DIGITS-1 -> 0.
  - Wrap to 0 is the frame boundary: frame counter increments.
  - At the frame boundary, if pending, the display buffer takes the shadow and pending clears.
- Decode is standard hex, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Digit i is blank when all of the following hold:
  - lzs=1;
  - i != 0;
  - display digits DIGITS-1..i are all 0;
  - dp bit i = 0.
- Segment value = blank ? 0 : {dp[idx], decode(digit[idx])}. lt=0 forces 0xFF and overrides blanking.
- Digit active when bi=1 and phase < brightness; dig_out bit idx = active, other bits 0. brightness 0 = dark.
- al=1 inverts both uo_out and dig_out.

Boundary cases:
- Commit write in the same cycle as a frame boundary: pending set, applied at the next boundary.
- Shadow write in the same cycle as a commit copy: copy takes the old value; the new value stays in shadow.
- Lowering div below the current pre: tick on the next cycle (>= compare).

## Timing
- Reset values:
  - uo_out=0xFF and dig_out=all ones (al=1, all off).
  - idx=0, phase=0, pre=0, frame=0, pending=0.
  - shadow and display buffer = 0.
- Outputs are registered from the current state: 1-cycle latency.
- buf=0 write at cycle t: display buffer updates at t+1, uo_out reflects it at t+2.
- Slot length = (div+1)*256 clk. Frame = DIGITS slots.
- Reset mid-scan: all state returns to reset values on the next edge. No partial commit.

## Configuration
- TQVP_MHD_DEADTIME_EN
  - Defined: dig_out is inactive while phase < 2 in every slot, whatever the brightness, to suppress ghosting.
  - Undefined: no dead time; active iff phase < brightness.

## Test plan
- Reset, DIGITS=4, div=0, write 0x0=0x21, 0x1=0x43 -> idx cycles 0..3 every 256 clk:
  - digit 0: uo_out=~0x06, dig_out=~4'b0001;
  - digit 3: uo_out=~0x66.
- lzs=1, digits 0x0007, dp=0 -> digits 3..1 blank (uo_out=0xFF), digit 0 shows ~0x07. Set dp[2] -> digit 2 shows ~0xBF and digit 3 stays blank.
- buf=1, write shadow 0x0=0x99 mid-frame -> display unchanged. Write 0x8 -> status bit7=1 until the next frame boundary, then digit 0 shows 9 and bit7=0.
- brightness=0x40, div=0 -> each slot dig_out active exactly 64 clk. With TQVP_MHD_DEADTIME_EN, active 62 clk starting at phase 2.
- lt=0 -> uo_out=0x00 on all digits. bi=0 -> dig_out all ones. al=0 -> polarity of both buses flipped.
- Commit write coincident with a frame boundary -> applied one frame later. Assert rst_n=0 mid-slot -> outputs 0xFF/all ones and frame counter 0 on the next edge.
